// File: rtl/edge_det_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
// Optional feature macro: EDGE_DET_SYNC_EN (2-flop input synchroniser per channel).
package edge_det_pkg;

  // Per-channel detection mode, two bits per channel on the mode bus.
  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  // Last sampled detect-path level of a channel.
  typedef enum logic {
    ZERO = 1'b0,
    ONE  = 1'b1
  } edge_state_t;

  // Decide whether a detected rise/fall is reported under the given mode.
  function automatic logic edge_fires(input logic [1:0] mode, input logic rise, input logic fall);
    logic fire;
    case (mode)
      EDGE_OFF:  fire = 1'b0;
      EDGE_RISE: fire = rise;
      EDGE_FALL: fire = fall;
      EDGE_BOTH: fire = rise | fall;
      default:   fire = 1'b0;
    endcase
    return fire;
  endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One edge-detector channel: optional synchroniser, two-state FSM holding the
// last detect-path level, Mealy tick, sticky pending flag and saturating counter.
// Optional feature macro: EDGE_DET_SYNC_EN (adds a 2-flop synchroniser on level).
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             level,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             tick,
  output logic             pending,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic             lv_s;
  edge_state_t      state_r;
  logic             rise_s;
  logic             fall_s;
  logic             tick_s;
  logic             pending_r;
  logic [CNT_W-1:0] count_r;

  // Increment that holds at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = CNT_MAX;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

`ifdef EDGE_DET_SYNC_EN
  logic sync1_r;
  logic sync2_r;

  // Two-flop synchroniser for asynchronous pins; cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= level;
      sync2_r <= sync1_r;
    end
  end

  assign lv_s = sync2_r;
`else
  assign lv_s = level;
`endif

  // Mealy edge decode: compare the stored level with the current detect-path level.
  always_comb begin
    rise_s = 1'b0;
    fall_s = 1'b0;
    tick_s = 1'b0;
    rise_s = (state_r == ZERO) & lv_s;
    fall_s = (state_r == ONE) & ~lv_s;
    tick_s = edge_fires(mode, rise_s, fall_s);
  end

  // State always tracks the level (mode-independent); pending and counter react to tick/clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ZERO;
      pending_r <= 1'b0;
      count_r   <= CNT_ZERO;
    end else begin
      state_r   <= lv_s ? ONE : ZERO;
      pending_r <= tick_s | (pending_r & ~clr);
      case ({clr, tick_s})
        2'b11:   count_r <= CNT_ONE;
        2'b10:   count_r <= CNT_ZERO;
        2'b01:   count_r <= sat_inc(count_r);
        default: count_r <= count_r;
      endcase
    end
  end

  assign tick    = tick_s;
  assign pending = pending_r;
  assign count   = count_r;

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: W independent edge_det_chan instances with
// per-channel mode, sticky pending flags, saturating counters and an
// OR-reduced pending summary for the interrupt logic.
// Optional feature macro: EDGE_DET_SYNC_EN (per-channel 2-flop synchroniser).
module edge_detect_multi
  import edge_det_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [W-1:0]       level,
  input  logic [2*W-1:0]     mode,
  input  logic [W-1:0]       clr,
  output logic [W-1:0]       tick,
  output logic [W-1:0]       pending,
  output logic               any_pending,
  output logic [W*CNT_W-1:0] count
);

  for (genvar i = 0; i < W; i++) begin : g_chan
    edge_det_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .level  (level[i]),
      .mode   (mode[2*i +: 2]),
      .clr    (clr[i]),
      .tick   (tick[i]),
      .pending(pending[i]),
      .count  (count[i*CNT_W +: CNT_W])
    );
  end

  assign any_pending = |pending;

endmodule
